// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI responder.
// Holds the FSM state enum, default word width and {CKP,CPH} mode codes.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // {CKP, CPH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser with history flop and edge pulses.
// Ports: clk, rst (async high), d in; lvl (synced level), rise, fall out.
module spi_sync_edge #(
  parameter int   N    = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync;
  logic         hist;

  // Edge pulses are registered so that every consumer sees them
  // alongside a settled history level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {N{INIT}};
      hist <= INIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], d};
      hist <= sync[N-1];
      rise <= sync[N-1] & ~hist;
      fall <= ~sync[N-1] & hist;
    end
  end

  assign lvl = hist;

endmodule

// File: rtl/spi_receptor.sv
// spi_receptor: SPI responder, all four CKP/CPH modes, multi-word per CS.
// Ports: clk, rst, CKP, CPH, SCK, CS, MOSI, data_in in;
//        MISO, data_out, data_valid, busy, abort out.
module spi_receptor
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              abort
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  logic sck_edge, lead, trail, samp, shft;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] rx, rx_n;
  logic [DATA_W-1:0] tx, tx_n;
  logic [DATA_W-1:0] dout_n, rx_word;
  logic              dv_n, ab_n;

  spi_sync_edge #(
    .N    (SYNC_STAGES),
    .INIT (1'b0)
  ) u_sck (
    .clk  (clk),
    .rst  (rst),
    .d    (SCK),
    .lvl  (sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(
    .N    (SYNC_STAGES),
    .INIT (1'b1)
  ) u_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (CS),
    .lvl  (cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // An edge that leaves the idle level is leading, one that
  // returns to it is trailing.
  assign sck_edge = sck_rise | sck_fall;
  assign lead     = sck_edge & (sck_lvl ^ CKP);
  assign trail    = sck_edge & ~(sck_lvl ^ CKP);

  always_comb begin
    samp = lead;
    shft = trail;
    unique case ({CKP, CPH})
      MODE0, MODE2: begin
        samp = lead;
        shft = trail;
      end
      MODE1, MODE3: begin
        samp = trail;
        shft = lead;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rx         <= '0;
      tx         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      abort      <= 1'b0;
      mosi_sync  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rx         <= rx_n;
      tx         <= tx_n;
      data_out   <= dout_n;
      data_valid <= dv_n;
      abort      <= ab_n;
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rx_n    = rx;
    tx_n    = tx;
    dout_n  = data_out;
    dv_n    = 1'b0;
    ab_n    = 1'b0;
    rx_word = {rx[DATA_W-2:0], mosi_s};
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (cs_fall) state_n = LOAD;
      end
      LOAD: begin
        tx_n    = data_in;
        cnt_n   = '0;
        state_n = cs_rise ? IDLE : SHIFT;
      end
      SHIFT: begin
        // No shift at a word boundary: the MSB just loaded must
        // survive the first shift edge of the word.
        if (shft && cnt != '0)
          tx_n = {tx[DATA_W-2:0], 1'b1};
        if (samp) begin
          rx_n = rx_word;
          if (cnt == LAST) begin
            cnt_n  = '0;
            dout_n = rx_word;
            dv_n   = 1'b1;
            tx_n   = data_in;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        // A word finishing in this same cycle leaves cnt_n at 0,
        // so it completes instead of aborting.
        if (cs_rise) begin
          ab_n    = (cnt_n != '0);
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = ~cs_lvl;
  assign MISO = (state == SHIFT) ? tx[DATA_W-1] : 1'b1;

endmodule

// File: tb/tb_spi_receptor.sv
// tb_spi_receptor: directed and randomized bench for spi_receptor.
// Bit-banged SPI master plus a word-level expectation model.
`timescale 1ns/1ps
module tb_spi_receptor;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, CKP, CPH, SCK, CS, MOSI, MISO;
  logic [7:0] data_in, data_out;
  logic       data_valid, busy, abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] dv_q[$];
  int         ab_cnt   = 0;
  int         busy_bad = 0;
  logic [7:0] tx_w[4];
  logic [7:0] din_w[4];
  logic [7:0] got_w[4];
  logic [7:0] last_dout = 8'h00;

  always #5 clk = ~clk;

  spi_receptor #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .CKP        (CKP),
    .CPH        (CPH),
    .SCK        (SCK),
    .CS         (CS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .data_in    (data_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .abort      (abort)
  );

  always @(negedge clk) begin
    if (data_valid) dv_q.push_back(data_out);
    if (abort) ab_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: MSB first, samples MISO on its own sample edge,
  // drives MOSI on the opposite edge.
  task automatic xfer(input logic [1:0] mode, input int nw,
                      input int cut);
    int total, nxt, w, i;
    nxt  = -1;
    CKP  = mode[1];
    CPH  = mode[0];
    SCK  = mode[1];
    data_in = din_w[0];
    clks(6);
    MOSI = CPH ? 1'b0 : tx_w[0][7];
    CS   = 1'b0;
    clks(8);
    if (nw > 1) data_in = din_w[1];
    total = (cut > 0) ? cut : nw * 8;
    for (int b = 0; b < total; b++) begin
      w = b / 8;
      i = 7 - (b % 8);
      if (CPH) MOSI = tx_w[w][i];
      else begin
        got_w[w][i] = MISO;
        busy_bad += int'(busy !== 1'b1);
      end
      if (nxt >= 0) begin
        data_in = din_w[nxt];
        nxt = -1;
      end
      SCK = ~CKP;
      if (!CPH && i == 0 && w + 2 < nw) nxt = w + 2;
      clks(HALF);
      if (CPH) begin
        got_w[w][i] = MISO;
        busy_bad += int'(busy !== 1'b1);
      end else if (b + 1 < total) begin
        MOSI = tx_w[(b+1)/8][7-((b+1)%8)];
      end
      if (nxt >= 0) begin
        data_in = din_w[nxt];
        nxt = -1;
      end
      SCK = CKP;
      if (CPH && i == 0 && w + 2 < nw) nxt = w + 2;
      clks(HALF);
    end
    clks(2);
    CS = 1'b1;
    clks(12);
  endtask

  task automatic run(input logic [1:0] mode, input int nw,
                     input int cut);
    int done, exp_ab;
    logic [31:0] got;
    dv_q.delete();
    ab_cnt   = 0;
    busy_bad = 0;
    xfer(mode, nw, cut);
    done   = (cut > 0) ? cut / 8 : nw;
    exp_ab = (cut > 0 && cut % 8 != 0) ? 1 : 0;
    chk("dv_count", dv_q.size(), done);
    for (int k = 0; k < done; k++) begin
      got = (k < dv_q.size()) ? 32'(dv_q[k]) : 32'hDEAD_BEEF;
      chk("data_out", got, tx_w[k]);
      chk("miso_word", got_w[k], din_w[k]);
    end
    chk("abort_count", ab_cnt, exp_ab);
    if (done > 0) last_dout = tx_w[done-1];
    chk("data_out_hold", data_out, last_dout);
    chk("busy_during", busy_bad, 0);
    chk("idle_miso", MISO, 1);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int nw, cut;
    logic [1:0] mode;
    rst = 1'b1; CS = 1'b1; SCK = 1'b0; CKP = 1'b0; CPH = 1'b0;
    MOSI = 1'b0; data_in = 8'h00;
    clks(3);
    chk("rst_miso", MISO, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    rst = 1'b0;
    clks(3);

    tx_w[0] = 8'h3C; din_w[0] = 8'hA5;
    run(MODE0, 1, 0);

    tx_w[0] = 8'h55; din_w[0] = 8'h0F;
    run(MODE3, 1, 0);

    tx_w[0] = 8'h12; din_w[0] = 8'hAA;
    tx_w[1] = 8'h34; din_w[1] = 8'hBB;
    run(MODE0, 2, 0);

    tx_w[0] = 8'hF0; din_w[0] = 8'h99;
    run(MODE0, 1, 5);
    tx_w[0] = 8'h81; din_w[0] = 8'h66;
    run(MODE0, 1, 0);

    // Reset in the middle of a byte.
    dv_q.delete();
    ab_cnt = 0;
    CKP = 1'b0; CPH = 1'b0; SCK = 1'b0;
    data_in = 8'h5A; MOSI = 1'b1; CS = 1'b0;
    clks(8);
    repeat (3) begin
      SCK = 1'b1; clks(HALF);
      SCK = 1'b0; clks(HALF);
    end
    SCK = 1'b1;
    clks(2);
    rst = 1'b1;
    #1;
    chk("midrst_miso", MISO, 1);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_abort", abort, 0);
    CS = 1'b1; SCK = 1'b0;
    clks(3);
    rst = 1'b0;
    last_dout = 8'h00;
    clks(6);
    chk("midrst_no_valid", dv_q.size(), 0);
    chk("midrst_no_abort", ab_cnt, 0);
    tx_w[0] = 8'hC3; din_w[0] = 8'h3A;
    run(MODE0, 1, 0);

    // SCK activity with CS high.
    dv_q.delete();
    ab_cnt = 0;
    for (int e = 0; e < 16; e++) begin
      SCK = ~SCK;
      clks(3);
      chk("cs_high_miso", MISO, 1);
      chk("cs_high_busy", busy, 0);
    end
    SCK = 1'b0;
    clks(6);
    chk("cs_high_no_valid", dv_q.size(), 0);
    chk("cs_high_no_abort", ab_cnt, 0);

    // Randomized transfers, some cut short.
    for (int r = 0; r < 10; r++) begin
      mode = 2'($urandom_range(0, 3));
      nw   = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        tx_w[k]  = 8'($urandom);
        din_w[k] = 8'($urandom);
      end
      cut = ($urandom_range(0, 2) == 0) ?
            $urandom_range(1, nw * 8 - 1) : 0;
      run(mode, nw, cut);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
